// File: rtl/serial_tx_4bit_if.sv
// Word-in / line-out bundle for serial_tx_4bit: parallel handshake toward the
// register bank plus the serial line, status flags and an FSM debug tap.
interface serial_tx_4bit_if #(
   parameter int WIDTH = 4
);
   logic             Enable;
   logic [WIDTH-1:0] Dato;
   logic             Load;
   logic             Ready;
   logic             Serial;
   logic             Busy;
   logic             Done;
   logic [1:0]       fsm_state;

   // Handshake: a word transfers at a rising edge where Load, Ready and Enable
   // are all high; Load in any other cycle is dropped, never queued.
   modport master (
      output Enable, Dato, Load,
      input  Ready, Serial, Busy, Done, fsm_state
   );

   modport slave (
      input  Enable, Dato, Load,
      output Ready, Serial, Busy, Done, fsm_state
   );
endinterface

// File: rtl/serial_tx_4bit.sv
// Parallel-in serial-out framer: start bit 0, WIDTH data bits LSB first,
// stop bit 1, each held for BIT_CYCLES enabled cycles; all outputs registered.
module serial_tx_4bit #(
   parameter int WIDTH      = 4,
   parameter int BIT_CYCLES = 1
) (
   input logic             Clk,
   input logic             Reset,
   serial_tx_4bit_if.slave bus
);
   localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
   localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] CYC_LAST = CW'(BIT_CYCLES - 1);
   localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   state_t           state, state_n;
   logic [WIDTH-1:0] shift_q, shift_n;
   logic [BW-1:0]    bit_cnt, bit_n;
   logic [CW-1:0]    cyc_cnt, cyc_n;
   logic             serial_q, serial_n;
   logic             ready_q, busy_q;
   logic             done_q, done_n;
   logic             tc;

   assign tc = (cyc_cnt == CYC_LAST);

   always_comb begin
      state_n = state;
      shift_n = shift_q;
      bit_n   = bit_cnt;
      cyc_n   = cyc_cnt;
      done_n  = 1'b0;

      if (bus.Enable) begin
         if (state == IDLE) begin
            if (bus.Load) begin
               state_n = START;
               shift_n = bus.Dato;
               bit_n   = '0;
               cyc_n   = '0;
            end
         end else if (!tc) begin
            cyc_n = cyc_cnt + CW'(1);
         end else begin
            cyc_n = '0;
            case (state)
               START: state_n = DATA;
               DATA: begin
                  shift_n = shift_q >> 1;
                  bit_n   = bit_cnt + BW'(1);
                  if (bit_cnt == BIT_LAST) begin
                     state_n = STOP;
                     bit_n   = '0;
                  end
               end
               STOP: begin
                  state_n = IDLE;
                  done_n  = 1'b1;
               end
               default: state_n = IDLE;
            endcase
         end
      end

      // Line level is computed from the upcoming state so Serial can be a flop.
      case (state_n)
         START:   serial_n = 1'b0;
         DATA:    serial_n = shift_n[0];
         default: serial_n = 1'b1;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state    <= IDLE;
         shift_q  <= '0;
         bit_cnt  <= '0;
         cyc_cnt  <= '0;
         serial_q <= 1'b1;
         ready_q  <= 1'b1;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state    <= state_n;
         shift_q  <= shift_n;
         bit_cnt  <= bit_n;
         cyc_cnt  <= cyc_n;
         serial_q <= serial_n;
         ready_q  <= (state_n == IDLE);
         busy_q   <= (state_n != IDLE);
         done_q   <= done_n;
      end
   end

   assign bus.Serial    = serial_q;
   assign bus.Ready     = ready_q;
   assign bus.Busy      = busy_q;
   assign bus.Done      = done_q;
   assign bus.fsm_state = state;
endmodule

// File: tb/tb_serial_tx_4bit.sv
// Bench for serial_tx_4bit: two instances (BIT_CYCLES 1 and 3) share stimulus
// and are checked every cycle against a frame-pattern reference model.
module tb_serial_tx_4bit;
   localparam int W = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst  = 1'b1;
   logic         en   = 1'b1;
   logic         ld   = 1'b0;
   logic [W-1:0] dato = '0;

   int n_cmp = 0;
   int n_err = 0;

   serial_tx_4bit_if #(.WIDTH(W)) bus_a ();
   serial_tx_4bit_if #(.WIDTH(W)) bus_b ();

   assign bus_a.Enable = en;
   assign bus_a.Load   = ld;
   assign bus_a.Dato   = dato;
   assign bus_b.Enable = en;
   assign bus_b.Load   = ld;
   assign bus_b.Dato   = dato;

   serial_tx_4bit #(.WIDTH(W), .BIT_CYCLES(1)) dut_a (.Clk(clk), .Reset(rst), .bus(bus_a));
   serial_tx_4bit #(.WIDTH(W), .BIT_CYCLES(3)) dut_b (.Clk(clk), .Reset(rst), .bus(bus_b));

   // Reference: on acceptance, the whole expected line waveform of the frame
   // is laid out as a bit pattern; each enabled edge plays the next bit.
   logic [63:0] pat [2];
   int          pos [2];
   int          len [2];
   logic        in_frame   [2];
   logic        exp_serial [2];
   logic        exp_ready  [2];
   logic        exp_busy   [2];
   logic        exp_done   [2];

   typedef struct packed {
      logic         rst;
      logic         en;
      logic         ld;
      logic [W-1:0] dato;
      logic         serial;
      logic         ready;
      logic         busy;
      logic         done;
   } vec_t;

   vec_t vecs [9];

   task automatic model_update();
      for (int g = 0; g < 2; g++) begin
         int bc;
         bc = (g == 0) ? 1 : 3;
         exp_done[g] = 1'b0;
         if (rst) begin
            in_frame[g]   = 1'b0;
            exp_serial[g] = 1'b1;
         end else if (en) begin
            if (in_frame[g]) begin
               if (pos[g] < len[g]) begin
                  exp_serial[g] = pat[g][pos[g]];
                  pos[g]++;
               end else begin
                  in_frame[g]   = 1'b0;
                  exp_serial[g] = 1'b1;
                  exp_done[g]   = 1'b1;
               end
            end else if (ld) begin
               len[g] = (W + 2) * bc;
               pat[g] = '0;
               for (int j = 0; j < len[g]; j++) begin
                  int k;
                  k = j / bc;
                  pat[g][j] = (k == 0) ? 1'b0 : (k == W + 1) ? 1'b1 : dato[k-1];
               end
               exp_serial[g] = pat[g][0];
               pos[g]        = 1;
               in_frame[g]   = 1'b1;
            end
         end
         exp_ready[g] = !in_frame[g];
         exp_busy[g]  = in_frame[g];
      end
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_model();
      check("a_serial", 32'(bus_a.Serial), 32'(exp_serial[0]));
      check("a_ready",  32'(bus_a.Ready),  32'(exp_ready[0]));
      check("a_busy",   32'(bus_a.Busy),   32'(exp_busy[0]));
      check("a_done",   32'(bus_a.Done),   32'(exp_done[0]));
      check("b_serial", 32'(bus_b.Serial), 32'(exp_serial[1]));
      check("b_ready",  32'(bus_b.Ready),  32'(exp_ready[1]));
      check("b_busy",   32'(bus_b.Busy),   32'(exp_busy[1]));
      check("b_done",   32'(bus_b.Done),   32'(exp_done[1]));
   endtask

   // Inputs change at the falling edge, outputs are sampled at the next one.
   task automatic step(input logic r, input logic e, input logic l, input logic [W-1:0] d);
      rst  = r;
      en   = e;
      ld   = l;
      dato = d;
      @(posedge clk);
      model_update();
      @(negedge clk);
      check_model();
   endtask

   initial begin
      logic [17:0]  got18;
      logic [3:0]   got4;
      logic [W-1:0] d;
      int           n, dn, a_cnt, b_cnt, a_t0, a_t1, b_t0, b_t1;

      for (int g = 0; g < 2; g++) begin
         in_frame[g] = 1'b0;
         pos[g]      = 0;
         len[g]      = 0;
      end

      vecs[0] = '{1'b1, 1'b1, 1'b0, 4'h0,    1'b1, 1'b1, 1'b0, 1'b0};
      vecs[1] = '{1'b0, 1'b1, 1'b1, 4'b1011, 1'b0, 1'b0, 1'b1, 1'b0};
      vecs[2] = '{1'b0, 1'b1, 1'b0, 4'hF,    1'b1, 1'b0, 1'b1, 1'b0};
      vecs[3] = '{1'b0, 1'b1, 1'b0, 4'h0,    1'b1, 1'b0, 1'b1, 1'b0};
      vecs[4] = '{1'b0, 1'b1, 1'b0, 4'h3,    1'b0, 1'b0, 1'b1, 1'b0};
      vecs[5] = '{1'b0, 1'b1, 1'b0, 4'h0,    1'b1, 1'b0, 1'b1, 1'b0};
      vecs[6] = '{1'b0, 1'b1, 1'b0, 4'h0,    1'b1, 1'b0, 1'b1, 1'b0};
      vecs[7] = '{1'b0, 1'b1, 1'b0, 4'h0,    1'b1, 1'b1, 1'b0, 1'b1};
      vecs[8] = '{1'b0, 1'b1, 1'b0, 4'h0,    1'b1, 1'b1, 1'b0, 1'b0};

      @(negedge clk);

      // Basic frame of 4'b1011 on the single-cycle-per-bit instance
      for (int i = 0; i < 9; i++) begin
         step(vecs[i].rst, vecs[i].en, vecs[i].ld, vecs[i].dato);
         check($sformatf("tbl%0d_serial", i), 32'(bus_a.Serial), 32'(vecs[i].serial));
         check($sformatf("tbl%0d_ready", i),  32'(bus_a.Ready),  32'(vecs[i].ready));
         check($sformatf("tbl%0d_busy", i),   32'(bus_a.Busy),   32'(vecs[i].busy));
         check($sformatf("tbl%0d_done", i),   32'(bus_a.Done),   32'(vecs[i].done));
      end

      // Bit stretching on the three-cycle instance; Dato scrambled after acceptance
      step(1'b1, 1'b1, 1'b0, '0);
      step(1'b0, 1'b1, 1'b1, 4'b0110);
      got18    = '0;
      got18[0] = bus_b.Serial;
      for (int k = 1; k < 18; k++) begin
         step(1'b0, 1'b1, 1'b0, W'($urandom_range(0, 15)));
         got18[k] = bus_b.Serial;
      end
      check("stretch_bits", 32'(got18), 32'(18'b111000111111000000));
      step(1'b0, 1'b1, 1'b0, '0);
      check("stretch_done", 32'(bus_b.Done), 32'd1);

      // Load while busy is dropped
      step(1'b1, 1'b1, 1'b0, '0);
      step(1'b0, 1'b1, 1'b1, 4'b0001);
      step(1'b0, 1'b1, 1'b0, '0);   got4[0] = bus_a.Serial;
      step(1'b0, 1'b1, 1'b1, 4'hF); got4[1] = bus_a.Serial;
      step(1'b0, 1'b1, 1'b0, '0);   got4[2] = bus_a.Serial;
      step(1'b0, 1'b1, 1'b0, '0);   got4[3] = bus_a.Serial;
      check("busy_load_bits", 32'(got4), 32'(4'b0001));
      step(1'b0, 1'b1, 1'b0, '0);
      step(1'b0, 1'b1, 1'b0, '0);
      check("busy_load_done", 32'(bus_a.Done), 32'd1);
      for (int k = 0; k < 8; k++) begin
         step(1'b0, 1'b1, 1'b0, '0);
         check("busy_load_idle_serial", 32'(bus_a.Serial), 32'd1);
         check("busy_load_idle_busy", 32'(bus_a.Busy), 32'd0);
      end

      // Enable dropped for 5 cycles during data bit 2
      step(1'b1, 1'b1, 1'b0, '0);
      step(1'b0, 1'b1, 1'b1, 4'b0100);
      step(1'b0, 1'b1, 1'b0, '0);
      step(1'b0, 1'b1, 1'b0, '0);
      step(1'b0, 1'b1, 1'b0, '0);
      check("gate_bit2", 32'(bus_a.Serial), 32'd1);
      for (int k = 0; k < 5; k++) begin
         step(1'b0, 1'b0, 1'b0, '0);
         check("gate_hold_serial", 32'(bus_a.Serial), 32'd1);
         check("gate_hold_busy", 32'(bus_a.Busy), 32'd1);
      end
      n = 0;
      for (int k = 0; k < 10; k++) begin
         step(1'b0, 1'b1, 1'b0, '0);
         n++;
         if (bus_a.Done) break;
      end
      check("gate_tail_cycles", 32'(n), 32'd3);
      for (int k = 0; k < 3; k++) begin
         step(1'b0, 1'b0, 1'b1, 4'hF);
         check("gate_idle_ready", 32'(bus_a.Ready), 32'd1);
         check("gate_idle_busy", 32'(bus_a.Busy), 32'd0);
      end
      step(1'b0, 1'b1, 1'b0, '0);
      check("gate_idle_no_accept", 32'(bus_a.Busy), 32'd0);

      // Reset during data bit 1 aborts the frame
      step(1'b1, 1'b1, 1'b0, '0);
      step(1'b0, 1'b1, 1'b1, 4'b0101);
      step(1'b0, 1'b1, 1'b0, '0);
      step(1'b0, 1'b1, 1'b0, '0);
      check("abort_bit1", 32'(bus_a.Serial), 32'd0);
      step(1'b1, 1'b1, 1'b1, 4'hF);
      check("abort_serial", 32'(bus_a.Serial), 32'd1);
      check("abort_ready", 32'(bus_a.Ready), 32'd1);
      check("abort_busy", 32'(bus_a.Busy), 32'd0);
      check("abort_done", 32'(bus_a.Done), 32'd0);
      dn = 0;
      for (int k = 0; k < 10; k++) begin
         step(1'b0, 1'b1, 1'b0, '0);
         dn += int'(bus_a.Done);
      end
      check("abort_no_done", 32'(dn), 32'd0);
      step(1'b0, 1'b1, 1'b1, 4'b1010);
      check("abort_restart_start", 32'(bus_a.Serial), 32'd0);
      for (int k = 0; k < 4; k++) begin
         step(1'b0, 1'b1, 1'b0, '0);
         got4[k] = bus_a.Serial;
      end
      check("abort_restart_bits", 32'(got4), 32'(4'b1010));
      step(1'b0, 1'b1, 1'b0, '0);
      step(1'b0, 1'b1, 1'b0, '0);
      check("abort_restart_done", 32'(bus_a.Done), 32'd1);

      // Back-to-back with Load held high, Dato alternating 5/A per frame
      step(1'b1, 1'b1, 1'b0, '0);
      d = 4'h5;
      a_cnt = 0; b_cnt = 0; a_t0 = -1; a_t1 = -1; b_t0 = -1; b_t1 = -1;
      for (int k = 0; k < 80; k++) begin
         step(1'b0, 1'b1, 1'b1, d);
         if (bus_a.Done) begin
            if (a_cnt == 0) a_t0 = k;
            if (a_cnt == 1) a_t1 = k;
            a_cnt++;
            d = (d == 4'h5) ? 4'hA : 4'h5;
         end
         if (bus_b.Done) begin
            if (b_cnt == 0) b_t0 = k;
            if (b_cnt == 1) b_t1 = k;
            b_cnt++;
         end
      end
      check("b2b_a_first_done", 32'(a_t0), 32'd6);
      check("b2b_a_period", 32'(a_t1 - a_t0), 32'd7);
      check("b2b_a_count", 32'(a_cnt), 32'd11);
      check("b2b_b_period", 32'(b_t1 - b_t0), 32'd19);
      check("b2b_b_count", 32'(b_cnt), 32'd4);

      // Randomized traffic against the model
      step(1'b1, 1'b1, 1'b0, '0);
      for (int k = 0; k < 400; k++) begin
         step($urandom_range(0, 99) == 0, $urandom_range(0, 9) != 0,
              $urandom_range(0, 3) == 0, W'($urandom_range(0, 15)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
